// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage and the pipeline
// registers built on it: FSM state encoding, datapath widths, the PC step
// and the bubble instruction value.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int                 INSTR_W   = 32;
  localparam logic [31:0]        PC_INC    = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // REQ and SQUASH are the two states with a read on the bus.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_SQUASH = 2'd2,
    ST_HOLD   = 2'd3
  } fetch_state_e;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// -----------------------------------------------------------------------------
// ifid_reg
// Pipeline register carrying one instruction word, its PC+4 and a valid bit.
// Priority: flush > stall > load > bubble.
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   load             : capture instr_in / pc_plus4_in as a real instruction
//   flush            : squash the held instruction (valid cleared, even stalled)
//   stall            : downstream cannot accept; hold everything
//   instr_in         : instruction word to capture
//   pc_plus4_in      : PC+4 belonging to instr_in
//   instr, pc_plus4  : registered instruction and PC+4
//   valid            : 1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module ifid_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [31:0]        pc_plus4_in,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc_plus4,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc_plus4_q, pc_plus4_d;
  logic               valid_q, valid_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/else leaves a signal unassigned and infers a latch.
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      // Data fields keep their old values; only the valid bit matters.
      valid_d = 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr_d    = instr_in;
        pc_plus4_d = pc_plus4_in;
        valid_d    = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
// MIPS instruction fetch: holds the PC, reads instruction memory over a
// req/ack handshake (one outstanding read), and delivers words through the
// IF/ID register. Handles decode stalls (one-entry hold buffer) and branch
// redirects (squashing a read already on the bus).
//   RESET_PC     : first fetch address after reset (word aligned)
//   Clk, Rst     : rising-edge clock, asynchronous active-high reset
//   Stall        : decode cannot accept; IF/ID holds
//   PCSrc        : redirect to BranchTarget (bits [1:0] ignored)
//   ImemReq      : read request, held until ImemAck
//   ImemAddr     : read address, stable while ImemReq=1
//   ImemAck      : one-cycle pulse, ImemRdata valid
//   ImemRdata    : instruction word from memory
//   Instruction  : IF/ID instruction to the decode controller
//   PCPlus4      : IF/ID PC+4 of Instruction
//   IFIDValid    : IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Stall,
  input  logic               PCSrc,
  input  logic [31:0]        BranchTarget,
  output logic               ImemReq,
  output logic [31:0]        ImemAddr,
  input  logic               ImemAck,
  input  logic [INSTR_W-1:0] ImemRdata,
  output logic [INSTR_W-1:0] Instruction,
  output logic [31:0]        PCPlus4,
  output logic               IFIDValid
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;
  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
  logic [31:0]        buf_pc4_q, buf_pc4_d;

  logic               ifid_load;
  logic [INSTR_W-1:0] ifid_instr_in;
  logic [31:0]        ifid_pc4_in;

  logic [31:0]        addr_plus4;
  logic [31:0]        target;

  assign addr_plus4 = addr_q + PC_INC;   // 32-bit modulo wrap is intended
  assign target     = word_align(BranchTarget);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    buf_instr_d   = buf_instr_q;
    buf_pc4_d     = buf_pc4_q;
    ifid_load     = 1'b0;
    ifid_instr_in = ImemRdata;
    ifid_pc4_in   = addr_plus4;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (PCSrc) begin
          pc_d   = target;
          addr_d = target;
        end
      end

      ST_REQ: begin
        if (PCSrc) begin
          pc_d = target;
          if (ImemAck) begin
            // Read finished this cycle: drop the word and fetch the target.
            addr_d = target;
          end else begin
            // Address must stay put until the pending read is acked.
            state_d = ST_SQUASH;
          end
        end else if (ImemAck) begin
          pc_d = addr_plus4;
          if (Stall) begin
            buf_instr_d = ImemRdata;
            buf_pc4_d   = addr_plus4;
            state_d     = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
            addr_d    = addr_plus4;
          end
        end
      end

      ST_SQUASH: begin
        if (PCSrc) pc_d = target;
        if (ImemAck) begin
          // Stale word is discarded; the newest redirect target wins.
          addr_d  = PCSrc ? target : pc_q;
          state_d = ST_REQ;
        end
      end

      ST_HOLD: begin
        if (PCSrc) begin
          pc_d    = target;
          addr_d  = target;
          state_d = ST_REQ;
        end else if (!Stall) begin
          ifid_load     = 1'b1;
          ifid_instr_in = buf_instr_q;
          ifid_pc4_in   = buf_pc4_q;
          addr_d        = pc_q;
          state_d       = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc4_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  assign ImemReq  = (state_q == ST_REQ) || (state_q == ST_SQUASH);
  assign ImemAddr = addr_q;

  // A redirect squashes IF/ID regardless of Stall.
  ifid_reg u_ifid (
    .clk         (Clk),
    .rst         (Rst),
    .load        (ifid_load),
    .flush       (PCSrc),
    .stall       (Stall),
    .instr_in    (ifid_instr_in),
    .pc_plus4_in (ifid_pc4_in),
    .instr       (Instruction),
    .pc_plus4    (PCPlus4),
    .valid       (IFIDValid)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
// Directed bench for instr_fetch_stage. Inputs change 1 time unit after the
// rising edge; outputs are read at the same point, i.e. after the edge has
// taken effect. A second instance with RESET_PC=0xFFFF_FFFC covers the wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdata;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        IFIDValid;

  logic        w_rst;
  logic        w_stall;
  logic        w_pcsrc;
  logic [31:0] w_target;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;

  int total = 0;
  int bad   = 0;

  instr_fetch_stage dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Stall        (Stall),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemAck      (ImemAck),
    .ImemRdata    (ImemRdata),
    .Instruction  (Instruction),
    .PCPlus4      (PCPlus4),
    .IFIDValid    (IFIDValid)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk          (Clk),
    .Rst          (w_rst),
    .Stall        (w_stall),
    .PCSrc        (w_pcsrc),
    .BranchTarget (w_target),
    .ImemReq      (w_req),
    .ImemAddr     (w_addr),
    .ImemAck      (w_ack),
    .ImemRdata    (w_rdata),
    .Instruction  (w_instr),
    .PCPlus4      (w_pc4),
    .IFIDValid    (w_valid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the main DUT in REQ at RESET_PC with all inputs idle.
  task automatic do_reset();
    Rst = 1'b1; ImemAck = 1'b0; Stall = 1'b0; PCSrc = 1'b0;
    BranchTarget = 32'h0; ImemRdata = 32'h0;
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1; Stall = 1'b0; PCSrc = 1'b0; BranchTarget = 32'h0;
    ImemAck = 1'b0; ImemRdata = 32'h0;
    #1;
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL rst0_req got=%b exp=0", ImemReq); end
    total++; if (ImemAddr !== 32'h0) begin bad++; $display("FAIL rst0_addr got=%h exp=%h", ImemAddr, 32'h0); end
    total++; if (IFIDValid !== 1'b0) begin bad++; $display("FAIL rst0_valid got=%b exp=0", IFIDValid); end
    tick();
    Rst = 1'b0;
    #1;
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL rel_idle_req got=%b exp=0", ImemReq); end
    tick();
    total++; if (ImemReq !== 1'b1) begin bad++; $display("FAIL rel_first_req got=%b exp=1", ImemReq); end
    total++; if (ImemAddr !== 32'h0) begin bad++; $display("FAIL rel_first_addr got=%h exp=%h", ImemAddr, 32'h0); end
    ImemAck = 1'b1; ImemRdata = 32'h1234_5678;
    tick();
    total++; if (IFIDValid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid got=%b exp=1", IFIDValid); end
    ImemAck = 1'b0;
    #2;
    Rst = 1'b1;   // mid-cycle, async
    #1;
    total++; if (Instruction !== 32'h0) begin bad++; $display("FAIL midrst_instr got=%h exp=%h", Instruction, 32'h0); end
    total++; if (PCPlus4 !== 32'h0) begin bad++; $display("FAIL midrst_pc4 got=%h exp=%h", PCPlus4, 32'h0); end
    total++; if (IFIDValid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", IFIDValid); end
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b exp=0", ImemReq); end
    total++; if (ImemAddr !== 32'h0) begin bad++; $display("FAIL midrst_addr got=%h exp=%h", ImemAddr, 32'h0); end
  endtask

  task automatic test_streaming();
    do_reset();
    ImemAck = 1'b1; ImemRdata = 32'h8C01_0004;
    tick();
    total++; if (Instruction !== 32'h8C01_0004) begin bad++; $display("FAIL str_instr0 got=%h exp=%h", Instruction, 32'h8C01_0004); end
    total++; if (PCPlus4 !== 32'h4 || IFIDValid !== 1'b1) begin bad++; $display("FAIL str_pc4_0 got=%h/%b exp=%h/1", PCPlus4, IFIDValid, 32'h4); end
    total++; if (ImemAddr !== 32'h4 || ImemReq !== 1'b1) begin bad++; $display("FAIL str_addr0 got=%h/%b exp=%h/1", ImemAddr, ImemReq, 32'h4); end
    ImemRdata = 32'hAC01_0008;
    tick();
    total++; if (Instruction !== 32'hAC01_0008) begin bad++; $display("FAIL str_instr1 got=%h exp=%h", Instruction, 32'hAC01_0008); end
    total++; if (PCPlus4 !== 32'h8 || IFIDValid !== 1'b1) begin bad++; $display("FAIL str_pc4_1 got=%h/%b exp=%h/1", PCPlus4, IFIDValid, 32'h8); end
    ImemRdata = 32'h1022_0003;
    tick();
    total++; if (Instruction !== 32'h1022_0003) begin bad++; $display("FAIL str_instr2 got=%h exp=%h", Instruction, 32'h1022_0003); end
    total++; if (PCPlus4 !== 32'hC || IFIDValid !== 1'b1) begin bad++; $display("FAIL str_pc4_2 got=%h/%b exp=%h/1", PCPlus4, IFIDValid, 32'hC); end
    ImemAck = 1'b0;
    tick();
    total++; if (IFIDValid !== 1'b0) begin bad++; $display("FAIL str_bubble_valid got=%b exp=0", IFIDValid); end
    total++; if (Instruction !== 32'h1022_0003) begin bad++; $display("FAIL str_bubble_instr got=%h exp=%h", Instruction, 32'h1022_0003); end
    total++; if (ImemAddr !== 32'hC || ImemReq !== 1'b1) begin bad++; $display("FAIL str_wait_addr got=%h/%b exp=%h/1", ImemAddr, ImemReq, 32'hC); end
  endtask

  task automatic test_stall();
    do_reset();
    ImemAck = 1'b1; ImemRdata = 32'h8C01_0004;
    tick();
    Stall = 1'b1; ImemRdata = 32'hAC01_0008;
    tick();
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL stl_req_drop got=%b exp=0", ImemReq); end
    total++; if (Instruction !== 32'h8C01_0004 || IFIDValid !== 1'b1) begin bad++; $display("FAIL stl_hold got=%h/%b exp=%h/1", Instruction, IFIDValid, 32'h8C01_0004); end
    ImemAck = 1'b1; ImemRdata = 32'hBAD0_BAD0;   // ack outside REQ must be ignored
    tick();
    ImemAck = 1'b0;
    total++; if (Instruction !== 32'h8C01_0004 || ImemReq !== 1'b0) begin bad++; $display("FAIL stl_hold2 got=%h/%b exp=%h/0", Instruction, ImemReq, 32'h8C01_0004); end
    Stall = 1'b0;
    tick();
    total++; if (Instruction !== 32'hAC01_0008) begin bad++; $display("FAIL stl_rel_instr got=%h exp=%h", Instruction, 32'hAC01_0008); end
    total++; if (PCPlus4 !== 32'h8 || IFIDValid !== 1'b1) begin bad++; $display("FAIL stl_rel_pc4 got=%h/%b exp=%h/1", PCPlus4, IFIDValid, 32'h8); end
    total++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h8) begin bad++; $display("FAIL stl_next_req got=%b/%h exp=1/%h", ImemReq, ImemAddr, 32'h8); end
    ImemAck = 1'b1; ImemRdata = 32'h1022_0003;
    tick();
    ImemAck = 1'b0;
    total++; if (Instruction !== 32'h1022_0003 || PCPlus4 !== 32'hC) begin bad++; $display("FAIL stl_after got=%h/%h exp=%h/%h", Instruction, PCPlus4, 32'h1022_0003, 32'hC); end
  endtask

  task automatic test_redirect();
    do_reset();
    ImemAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ImemRdata = 32'hA000_0000 + i;
      tick();
    end
    ImemAck = 1'b0;
    total++; if (ImemAddr !== 32'h10) begin bad++; $display("FAIL rdr_pre_addr got=%h exp=%h", ImemAddr, 32'h10); end
    PCSrc = 1'b1; BranchTarget = 32'h40;
    tick();
    PCSrc = 1'b0;
    total++; if (IFIDValid !== 1'b0) begin bad++; $display("FAIL rdr_flush got=%b exp=0", IFIDValid); end
    total++; if (ImemAddr !== 32'h10 || ImemReq !== 1'b1) begin bad++; $display("FAIL rdr_addr_stable got=%h/%b exp=%h/1", ImemAddr, ImemReq, 32'h10); end
    tick();
    tick();
    total++; if (IFIDValid !== 1'b0 || ImemAddr !== 32'h10) begin bad++; $display("FAIL rdr_wait got=%b/%h exp=0/%h", IFIDValid, ImemAddr, 32'h10); end
    ImemAck = 1'b1; ImemRdata = 32'hDEAD_BEEF;
    tick();
    total++; if (IFIDValid !== 1'b0) begin bad++; $display("FAIL rdr_stale_drop got=%b exp=0", IFIDValid); end
    total++; if (ImemAddr !== 32'h40 || ImemReq !== 1'b1) begin bad++; $display("FAIL rdr_target_addr got=%h/%b exp=%h/1", ImemAddr, ImemReq, 32'h40); end
    ImemRdata = 32'h1111_1111;
    tick();
    ImemAck = 1'b0;
    total++; if (Instruction !== 32'h1111_1111 || PCPlus4 !== 32'h44 || IFIDValid !== 1'b1) begin bad++; $display("FAIL rdr_first got=%h/%h/%b exp=%h/%h/1", Instruction, PCPlus4, IFIDValid, 32'h1111_1111, 32'h44); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ImemAck = 1'b1; ImemRdata = 32'h2222_2222; PCSrc = 1'b1; BranchTarget = 32'h80;
    tick();
    PCSrc = 1'b0;
    total++; if (IFIDValid !== 1'b0 || Instruction !== 32'h0) begin bad++; $display("FAIL sim_ack_drop got=%b/%h exp=0/%h", IFIDValid, Instruction, 32'h0); end
    total++; if (ImemAddr !== 32'h80 || ImemReq !== 1'b1) begin bad++; $display("FAIL sim_ack_addr got=%h/%b exp=%h/1", ImemAddr, ImemReq, 32'h80); end
    ImemRdata = 32'h3333_3333;
    tick();
    ImemAck = 1'b0;
    total++; if (Instruction !== 32'h3333_3333 || PCPlus4 !== 32'h84 || IFIDValid !== 1'b1) begin bad++; $display("FAIL sim_tgt_word got=%h/%h/%b exp=%h/%h/1", Instruction, PCPlus4, IFIDValid, 32'h3333_3333, 32'h84); end
    Stall = 1'b1; PCSrc = 1'b1; BranchTarget = 32'h43;
    tick();
    PCSrc = 1'b0; Stall = 1'b0;
    total++; if (IFIDValid !== 1'b0) begin bad++; $display("FAIL sim_stall_flush got=%b exp=0", IFIDValid); end
    total++; if (ImemAddr !== 32'h84) begin bad++; $display("FAIL sim_squash_addr got=%h exp=%h", ImemAddr, 32'h84); end
    ImemAck = 1'b1; ImemRdata = 32'hDEAD_0000;
    tick();
    total++; if (ImemAddr !== 32'h40 || IFIDValid !== 1'b0) begin bad++; $display("FAIL sim_align_addr got=%h/%b exp=%h/0", ImemAddr, IFIDValid, 32'h40); end
    ImemRdata = 32'h4444_4444;
    tick();
    total++; if (Instruction !== 32'h4444_4444 || PCPlus4 !== 32'h44) begin bad++; $display("FAIL sim_align_word got=%h/%h exp=%h/%h", Instruction, PCPlus4, 32'h4444_4444, 32'h44); end
    // Redirect while a stalled word sits in the hold buffer.
    Stall = 1'b1; ImemRdata = 32'h5555_5555;
    tick();
    ImemAck = 1'b0;
    total++; if (ImemReq !== 1'b0 || Instruction !== 32'h4444_4444) begin bad++; $display("FAIL sim_hold got=%b/%h exp=0/%h", ImemReq, Instruction, 32'h4444_4444); end
    PCSrc = 1'b1; BranchTarget = 32'h100;
    tick();
    PCSrc = 1'b0; Stall = 1'b0;
    total++; if (IFIDValid !== 1'b0 || ImemAddr !== 32'h100 || ImemReq !== 1'b1) begin bad++; $display("FAIL sim_hold_rdr got=%b/%h/%b exp=0/%h/1", IFIDValid, ImemAddr, ImemReq, 32'h100); end
    ImemAck = 1'b1; ImemRdata = 32'h6666_6666;
    tick();
    ImemAck = 1'b0;
    total++; if (Instruction !== 32'h6666_6666 || PCPlus4 !== 32'h104 || IFIDValid !== 1'b1) begin bad++; $display("FAIL sim_hold_tgt got=%h/%h/%b exp=%h/%h/1", Instruction, PCPlus4, IFIDValid, 32'h6666_6666, 32'h104); end
  endtask

  task automatic test_wrap();
    w_rst = 1'b0;
    tick();
    total++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first got=%b/%h exp=1/%h", w_req, w_addr, 32'hFFFF_FFFC); end
    w_ack = 1'b1; w_rdata = 32'h7777_7777;
    tick();
    w_ack = 1'b0;
    total++; if (w_instr !== 32'h7777_7777 || w_pc4 !== 32'h0 || w_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc4 got=%h/%h/%b exp=%h/%h/1", w_instr, w_pc4, w_valid, 32'h7777_7777, 32'h0); end
    total++; if (w_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h exp=%h", w_addr, 32'h0); end
  endtask

  task automatic test_late_ack();
    do_reset();
    #2;
    Rst = 1'b1;
    #1;
    Rst = 1'b0;
    ImemAck = 1'b1; ImemRdata = 32'h9999_9999;
    tick();
    ImemAck = 1'b0;
    total++; if (IFIDValid !== 1'b0 || Instruction !== 32'h0) begin bad++; $display("FAIL late_ack_ignored got=%b/%h exp=0/%h", IFIDValid, Instruction, 32'h0); end
    total++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin bad++; $display("FAIL late_ack_req got=%b/%h exp=1/%h", ImemReq, ImemAddr, 32'h0); end
  endtask

  initial begin
    w_rst = 1'b1; w_stall = 1'b0; w_pcsrc = 1'b0; w_target = 32'h0;
    w_ack = 1'b0; w_rdata = 32'h0;
    test_reset();
    test_streaming();
    test_stall();
    test_redirect();
    test_simultaneous();
    test_wrap();
    test_late_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
